spike_mac_acc: RTL and testbench

SPIKE_MAC_ACC -- requirements
Module: spike_mac_acc

---
 rtl/spike_mac_acc.sv | 99 +++++++++
 tb/tb_spike_mac_acc.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/spike_mac_acc.sv
// Spike-gated shift-and-add MAC: accumulates per-beat spike products over a frame
// and hands the saturated frame sum out through a valid/ready result port.
module spike_mac_acc #(
    parameter int W     = 8,
    parameter int N     = 4,
    parameter int ACC_W = 12,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     beta,
    input  logic [W-1:0]     potential,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_sat,
    output logic [CNT_W-1:0] out_cnt
);

    typedef enum logic {ACCUM = 1'b0, OUT = 1'b1} state_t;

    state_t             state_q, state_d;
    logic               rdy_q;
    logic               p_valid_q;
    logic [W:0]         p_sum_q;
    logic               p_last_q;
    logic [ACC_W-1:0]   acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               sat_q;

    logic [W:0]         prod;
    logic [ACC_W:0]     acc_sum;
    logic               accept;
    logic               drain;

    // Channel i weights the potential by 2^-(N-1-i); each term truncates on its own.
    always_comb begin
        prod = '0;
        for (int i = 0; i < N; i++) begin
            if (beta[i]) prod = prod + {1'b0, potential >> (N - 1 - i)};
        end
    end

    // rdy_q keeps in_ready low until the first edge after reset release.
    assign in_ready  = rdy_q && (state_q == ACCUM) && !(p_valid_q && p_last_q);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == OUT);
    assign drain     = out_valid && out_ready;
    assign acc_sum   = {1'b0, acc_q} + {{(ACC_W - W){1'b0}}, p_sum_q};
    assign out_data  = acc_q;
    assign out_sat   = sat_q;
    assign out_cnt   = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ACCUM;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   if (p_valid_q && p_last_q) state_d = OUT;
            OUT:     if (out_ready)             state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q     <= 1'b0;
            p_valid_q <= 1'b0;
            p_sum_q   <= '0;
            p_last_q  <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
        end else begin
            rdy_q     <= 1'b1;
            p_valid_q <= accept;
            if (accept) begin
                p_sum_q  <= prod;
                p_last_q <= in_last;
            end
            if (drain) begin
                acc_q <= '0;
                cnt_q <= '0;
                sat_q <= 1'b0;
            end else if (p_valid_q) begin
                acc_q <= acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
                if (acc_sum[ACC_W]) sat_q <= 1'b1;
                if (!(&cnt_q))      cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spike_mac_acc.sv
// Directed bench for spike_mac_acc at W=8, N=4, ACC_W=12, CNT_W=8.
module tb_spike_mac_acc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  beta;
    logic [7:0]  potential;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_data;
    logic        out_sat;
    logic [7:0]  out_cnt;

    int checks   = 0;
    int failures = 0;

    spike_mac_acc #(.W(8), .N(4), .ACC_W(12), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .beta      (beta),
        .potential (potential),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_cnt   (out_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat, hold it until accepted (bounded), then drop in_valid.
    task automatic beat(input logic [3:0] b, input logic [7:0] p, input logic l);
        int t;
        t = 0;
        in_valid = 1'b1; beta = b; potential = p; in_last = l;
        while (!in_ready && t < 20) begin
            tick();
            t++;
        end
        chk("beat_accept_timeout", (t < 20), 1);
        tick();
        in_valid = 1'b0;
    endtask

    // Wait for a result (bounded), check it, then consume it.
    task automatic frame(input string tag, input logic [11:0] d, input logic [7:0] c, input logic s);
        int t;
        t = 0;
        while (!out_valid && t < 20) begin
            tick();
            t++;
        end
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_data"}, out_data, d);
        chk({tag, "_cnt"}, out_cnt, c);
        chk({tag, "_sat"}, out_sat, s);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_drained"}, out_valid, 0);
        chk({tag, "_ready_after"}, in_ready, 1);
        chk({tag, "_acc_clear"}, out_data, 0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; beta = '0; potential = '0; in_last = 1'b0; out_ready = 1'b0;
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_cnt", out_cnt, 0);
        chk("rst_out_sat", out_sat, 0);
        #20;                     // t=22, between edges
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready_pre_edge", in_ready, 0);
        tick();
        chk("rel_in_ready_post_edge", in_ready, 1);

        // Single beat, all channels: 25+50+100+200
        beat(4'b1111, 8'd200, 1'b1);
        chk("lat_c1_not_valid", out_valid, 0);
        chk("lat_c1_in_ready", in_ready, 0);
        tick();
        chk("lat_c2_valid", out_valid, 1);
        frame("b1111_200", 12'd375, 8'd1, 1'b0);

        // 7>>3 + 7>>1 = 0 + 3
        beat(4'b0101, 8'd7, 1'b1);
        frame("b0101_7", 12'd3, 8'd1, 1'b0);
        beat(4'b0000, 8'd255, 1'b1);
        frame("b0000_255", 12'd0, 8'd1, 1'b0);

        // 12 x 476 = 5712 saturates to 4095
        for (int i = 1; i <= 12; i++) beat(4'b1111, 8'd255, (i == 12));
        frame("sat12", 12'd4095, 8'd12, 1'b1);

        // Backpressure
        for (int i = 1; i <= 3; i++) beat(4'b1000, 8'd10, (i == 3));
        tick();
        in_valid = 1'b1; beta = 4'b1000; potential = 8'd99; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", out_valid, 1);
            chk("bp_data", out_data, 30);
            chk("bp_cnt", out_cnt, 3);
            chk("bp_in_ready", in_ready, 0);
            tick();
        end
        in_valid = 1'b0;
        frame("bp", 12'd30, 8'd3, 1'b0);
        beat(4'b1000, 8'd4, 1'b1);
        frame("bp_next", 12'd4, 8'd1, 1'b0);

        // Reset mid-frame
        for (int i = 0; i < 3; i++) beat(4'b1000, 8'd9, 1'b0);
        chk("mid_partial_acc", out_data, 18);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_cnt", out_cnt, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        #2;
        rst_n = 1'b1;
        tick();
        chk("mid_rel_ready", in_ready, 1);
        beat(4'b1000, 8'd9, 1'b1);
        frame("after_rst", 12'd9, 8'd1, 1'b0);

        // Gapped beats: 64>>2 = 16 each
        for (int i = 1; i <= 4; i++) begin
            beat(4'b0010, 8'd64, (i == 4));
            if (i < 4) begin
                tick();
                tick();
                chk("gap_acc", out_data, 12'(16 * i));
                chk("gap_cnt", out_cnt, i);
            end
        end
        frame("gapped", 12'd64, 8'd4, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
